// File: rtl/pc_flag_unit.sv
// Next-PC / N-Z-V flag / overflow-exception stage that sits directly behind the ALU.
// Latency: pc, flags, epc and exc_active update one clk edge after the deciding inputs; taken/link_* are combinational.
// Backpressure: stall=1 freezes every register and forces taken=0, link_we=0.
module pc_flag_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] alu_sum,
    input  logic        alu_zout,
    input  logic [2:0]  alu_status,
    input  logic        flag_we,
    input  logic        ovf_trap_en,
    input  logic [2:0]  br_type,
    input  logic        eret,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [2:0]  flags,
    output logic [31:0] epc,
    output logic        exc_active,
    output logic        taken,
    output logic        link_we,
    output logic [31:0] link_data
);

    // Decoded branch/jump types.
    localparam logic [2:0] BR_SEQ = 3'b000;
    localparam logic [2:0] BR_BEQ = 3'b001;
    localparam logic [2:0] BR_BRZ = 3'b010;
    localparam logic [2:0] BR_BRN = 3'b011;
    localparam logic [2:0] BR_BRV = 3'b100;
    localparam logic [2:0] BR_J   = 3'b101;
    localparam logic [2:0] BR_JAL = 3'b110;
    localparam logic [2:0] BR_JR  = 3'b111;

    // Positions inside the {n,z,v} flag vector.
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    // Architectural state.
    state_t      r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_flags;
    logic [31:0] r_epc;

    // Next-state values and datapath wires.
    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [2:0]  w_flags_nxt;
    logic [31:0] w_epc_nxt;

    logic [31:0] w_pc4;
    logic [31:0] w_btarget;
    logic [31:0] w_jaddr;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_run;
    logic        w_trap;
    logic        w_eret_go;
    logic        w_is_jal;

    // alu_sum has no consumer in this datapath (jr always takes rs_data), and
    // the top two offset bits shift out of the word-to-byte conversion.
    logic        w_unused;
    assign w_unused = ^{alu_sum, imm_ext[31:30]};

    // Target arithmetic; all sums wrap modulo 2^32.
    assign w_pc4     = r_pc + 32'd4;
    assign w_btarget = w_pc4 + {imm_ext[29:0], 2'b00};
    assign w_jaddr   = {w_pc4[31:28], jtarget, 2'b00};

    assign w_run    = (r_state == ST_RUN);
    assign w_is_jal = (br_type == BR_JAL);

    // A trap needs a flag-setting op in RUN with V set and trapping enabled;
    // in EXC a second overflow is deliberately ignored so epc is not clobbered.
    assign w_trap = w_run & ~stall & flag_we & ovf_trap_en & alu_status[FLAG_V];

    // eret is only meaningful while handling an exception.
    assign w_eret_go = ~w_run & ~stall & eret;

    // Branch condition and target select; conditional branches read the stored
    // flags so a same-cycle flag write is not seen until the following cycle.
    always_comb begin
        w_br_taken  = 1'b0;
        w_br_target = w_pc4;
        case (br_type)
            BR_SEQ: begin
                w_br_taken  = 1'b0;
                w_br_target = w_pc4;
            end
            BR_BEQ: begin
                w_br_taken  = alu_zout;
                w_br_target = w_btarget;
            end
            BR_BRZ: begin
                w_br_taken  = r_flags[FLAG_Z];
                w_br_target = w_btarget;
            end
            BR_BRN: begin
                w_br_taken  = r_flags[FLAG_N];
                w_br_target = w_btarget;
            end
            BR_BRV: begin
                w_br_taken  = r_flags[FLAG_V];
                w_br_target = w_btarget;
            end
            BR_J: begin
                w_br_taken  = 1'b1;
                w_br_target = w_jaddr;
            end
            BR_JAL: begin
                w_br_taken  = 1'b1;
                w_br_target = w_jaddr;
            end
            BR_JR: begin
                w_br_taken  = 1'b1;
                w_br_target = rs_data;
            end
        endcase
    end

    // Next-state logic: stall > trap > eret > branch/jump/sequential.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flags_nxt = r_flags;
        w_epc_nxt   = r_epc;
        if (!stall) begin
            if (w_trap) begin
                // Flags still latch on a trap so the handler sees V=1.
                w_state_nxt = ST_EXC;
                w_pc_nxt    = EXC_VECTOR;
                w_flags_nxt = alu_status;
                w_epc_nxt   = r_pc;
            end else if (w_eret_go) begin
                // Resume after the trapping instruction; epc is left intact.
                w_state_nxt = ST_RUN;
                w_pc_nxt    = r_epc + 32'd4;
            end else begin
                w_pc_nxt = w_br_taken ? w_br_target : w_pc4;
                // Flags are frozen while in EXC.
                if (w_run && flag_we) begin
                    w_flags_nxt = alu_status;
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_flags <= 3'b000;
            r_epc   <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flags <= w_flags_nxt;
            r_epc   <= w_epc_nxt;
        end
    end

    // Redirect indication: any non-sequential PC source, never under stall.
    assign taken = ~stall & (w_trap | w_eret_go | w_br_taken);

    // Link write only when the jal actually retires (not stalled, not
    // overridden by a trap or an eret).
    assign link_we   = ~stall & ~w_trap & ~w_eret_go & w_is_jal;
    assign link_data = w_pc4;

    assign pc         = r_pc;
    assign flags      = r_flags;
    assign epc        = r_epc;
    assign exc_active = (r_state == ST_EXC);

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed bench for pc_flag_unit with a scoreboard of expected register state.
// Each step: drive inputs, check combinational outputs, push expected next state, pop and compare after the edge.
// stall is driven by the bench; no backpressure from the DUT.
module tb_pc_flag_unit;

    localparam logic [2:0] BR_SEQ = 3'b000;
    localparam logic [2:0] BR_BEQ = 3'b001;
    localparam logic [2:0] BR_BRZ = 3'b010;
    localparam logic [2:0] BR_BRN = 3'b011;
    localparam logic [2:0] BR_BRV = 3'b100;
    localparam logic [2:0] BR_J   = 3'b101;
    localparam logic [2:0] BR_JAL = 3'b110;
    localparam logic [2:0] BR_JR  = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] alu_sum;
    logic        alu_zout;
    logic [2:0]  alu_status;
    logic        flag_we;
    logic        ovf_trap_en;
    logic [2:0]  br_type;
    logic        eret;
    logic [31:0] imm_ext;
    logic [25:0] jtarget;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [2:0]  flags;
    logic [31:0] epc;
    logic        exc_active;
    logic        taken;
    logic        link_we;
    logic [31:0] link_data;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  flags;
        logic [31:0] epc;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_pc     = 32'h0;
    bit          m_pc_known = 1'b0;

    always #5 clk = ~clk;

    pc_flag_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .alu_sum     (alu_sum),
        .alu_zout    (alu_zout),
        .alu_status  (alu_status),
        .flag_we     (flag_we),
        .ovf_trap_en (ovf_trap_en),
        .br_type     (br_type),
        .eret        (eret),
        .imm_ext     (imm_ext),
        .jtarget     (jtarget),
        .rs_data     (rs_data),
        .pc          (pc),
        .flags       (flags),
        .epc         (epc),
        .exc_active  (exc_active),
        .taken       (taken),
        .link_we     (link_we),
        .link_data   (link_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        stall       = 1'b0;
        alu_sum     = 32'hDEAD_BEEF;
        alu_zout    = 1'b0;
        alu_status  = 3'b000;
        flag_we     = 1'b0;
        ovf_trap_en = 1'b0;
        br_type     = BR_SEQ;
        eret        = 1'b0;
        imm_ext     = 32'h0;
        jtarget     = 26'h0;
        rs_data     = 32'h0;
    endtask

    // Inputs are already driven; check combinational outputs, queue the
    // expected post-edge state, then compare it after the edge.
    task automatic tick(input string tag, input logic e_taken, input logic e_lwe,
                        input logic [31:0] e_pc, input logic [2:0] e_flags,
                        input logic [31:0] e_epc, input logic e_exc);
        exp_t e;
        #1;
        chk({tag, ".taken"}, {31'h0, taken}, {31'h0, e_taken});
        chk({tag, ".link_we"}, {31'h0, link_we}, {31'h0, e_lwe});
        if (m_pc_known) chk({tag, ".link_data"}, link_data, m_pc + 32'd4);
        e.pc    = e_pc;
        e.flags = e_flags;
        e.epc   = e_epc;
        e.exc   = e_exc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".pc"}, pc, e.pc);
            chk({tag, ".flags"}, {29'h0, flags}, {29'h0, e.flags});
            chk({tag, ".epc"}, epc, e.epc);
            chk({tag, ".exc"}, {31'h0, exc_active}, {31'h0, e.exc});
            m_pc       = e.pc;
            m_pc_known = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst_n = 1'b0;
        tick("reset", 0, 0, 32'h0, 3'b000, 32'h0, 0);
        rst_n = 1'b1;

        // Sequential run after reset.
        clr(); tick("seq1", 0, 0, 32'h4, 3'b000, 32'h0, 0);
        clr(); tick("seq2", 0, 0, 32'h8, 3'b000, 32'h0, 0);
        clr(); tick("seq3", 0, 0, 32'hC, 3'b000, 32'h0, 0);

        // Jump to 0x100, latch Z, then brz back with offset -2.
        clr(); br_type = BR_J; jtarget = 26'h40;
        tick("j100", 1, 0, 32'h100, 3'b000, 32'h0, 0);
        clr(); flag_we = 1'b1; alu_status = 3'b010;
        tick("fwe_z", 0, 0, 32'h104, 3'b010, 32'h0, 0);
        clr(); br_type = BR_BRZ; imm_ext = 32'hFFFF_FFFE;
        tick("brz_back", 1, 0, 32'h100, 3'b010, 32'h0, 0);

        // beq on live zero with same-cycle N write, then brn on stored N.
        clr(); br_type = BR_J; jtarget = 26'h80;
        tick("j200", 1, 0, 32'h200, 3'b010, 32'h0, 0);
        clr(); br_type = BR_BEQ; alu_zout = 1'b1; imm_ext = 32'd4; flag_we = 1'b1; alu_status = 3'b100;
        tick("beq", 1, 0, 32'h214, 3'b100, 32'h0, 0);
        clr(); br_type = BR_BRN; imm_ext = 32'd4;
        tick("brn", 1, 0, 32'h228, 3'b100, 32'h0, 0);

        // Same-cycle flag write invisible to brz; brv not taken with V=0.
        clr(); br_type = BR_BRZ; imm_ext = 32'd8; flag_we = 1'b1; alu_status = 3'b010;
        tick("brz_stale", 0, 0, 32'h22C, 3'b010, 32'h0, 0);
        clr(); br_type = BR_BRV; imm_ext = 32'd8;
        tick("brv_nt", 0, 0, 32'h230, 3'b010, 32'h0, 0);

        // Overflow trap at 0x40 while a jal is decoded.
        clr(); br_type = BR_J; jtarget = 26'h10;
        tick("j40", 1, 0, 32'h40, 3'b010, 32'h0, 0);
        clr(); br_type = BR_JAL; jtarget = 26'h55; flag_we = 1'b1; alu_status = 3'b001; ovf_trap_en = 1'b1;
        tick("trap_jal", 1, 0, 32'h80, 3'b001, 32'h40, 1);

        // In EXC: second overflow ignored, flags frozen, branches still work.
        clr(); flag_we = 1'b1; alu_status = 3'b111; ovf_trap_en = 1'b1;
        tick("exc_ovf2", 0, 0, 32'h84, 3'b001, 32'h40, 1);
        clr(); br_type = BR_BRV; imm_ext = 32'd2;
        tick("exc_brv", 1, 0, 32'h90, 3'b001, 32'h40, 1);
        clr(); eret = 1'b1;
        tick("eret", 1, 0, 32'h44, 3'b001, 32'h40, 0);
        clr(); eret = 1'b1;
        tick("eret_run", 0, 0, 32'h48, 3'b001, 32'h40, 0);

        // Stall holds everything, even with jumps, flag writes and trap enables.
        clr(); stall = 1'b1; br_type = BR_J; jtarget = 26'h123; flag_we = 1'b1; alu_status = 3'b111;
        tick("stall1", 0, 0, 32'h48, 3'b001, 32'h40, 0);
        clr(); stall = 1'b1; br_type = BR_J; jtarget = 26'h123; flag_we = 1'b1; alu_status = 3'b111; ovf_trap_en = 1'b1;
        tick("stall2", 0, 0, 32'h48, 3'b001, 32'h40, 0);
        clr(); stall = 1'b1; br_type = BR_JAL; jtarget = 26'h123;
        tick("stall3", 0, 0, 32'h48, 3'b001, 32'h40, 0);

        // jr to 0x3000_0010 then jal within that segment.
        clr(); br_type = BR_JR; rs_data = 32'h3000_0010;
        tick("jr", 1, 0, 32'h3000_0010, 3'b001, 32'h40, 0);
        clr(); br_type = BR_JAL; jtarget = 26'h100;
        tick("jal", 1, 1, 32'h3000_0400, 3'b001, 32'h40, 0);

        // PC wrap.
        clr(); br_type = BR_JR; rs_data = 32'hFFFF_FFFC;
        tick("jr_top", 1, 0, 32'hFFFF_FFFC, 3'b001, 32'h40, 0);
        clr(); tick("wrap", 0, 0, 32'h0, 3'b001, 32'h40, 0);

        // Reset while in EXC.
        clr(); br_type = BR_J; jtarget = 26'h10;
        tick("j40b", 1, 0, 32'h40, 3'b001, 32'h40, 0);
        clr(); flag_we = 1'b1; alu_status = 3'b001; ovf_trap_en = 1'b1;
        tick("trap2", 1, 0, 32'h80, 3'b001, 32'h40, 1);
        clr(); rst_n = 1'b0;
        tick("rst_exc", 0, 0, 32'h0, 3'b000, 32'h0, 0);
        rst_n = 1'b1;
        clr(); tick("post_rst", 0, 0, 32'h4, 3'b000, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
